// File: rtl/sub_top_mm_to_st_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module : sub_top_mm_to_st_pkt_fifo
// Brief  : Avalon-MM write slave feeding a FWFT packet FIFO with Avalon-ST out
// Rev    : 1.0  initial release
// ============================================================================
module sub_top_mm_to_st_pkt_fifo #(
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 16,
    parameter int BYTE_SWAP     = 1,
    parameter int AFULL_DEFAULT = 14,
    parameter int EMPTY_W       = ($clog2(DATA_WIDTH/8) > 1) ? $clog2(DATA_WIDTH/8) : 1
) (
    input  logic                  wrclock,
    input  logic                  reset,
    input  logic [1:0]            avalonmm_write_slave_address,
    input  logic                  avalonmm_write_slave_write,
    input  logic                  avalonmm_write_slave_read,
    input  logic [DATA_WIDTH-1:0] avalonmm_write_slave_writedata,
    output logic [31:0]           avalonmm_write_slave_readdata,
    output logic                  avalonmm_write_slave_waitrequest,
    output logic [DATA_WIDTH-1:0] avalonst_source_data,
    output logic                  avalonst_source_valid,
    input  logic                  avalonst_source_ready,
    output logic                  avalonst_source_startofpacket,
    output logic                  avalonst_source_endofpacket,
    output logic [EMPTY_W-1:0]    avalonst_source_empty,
    output logic                  irq
);
    localparam int c_CNT_W     = $clog2(DEPTH + 1);
    localparam int c_RAM_DEPTH = DEPTH - 1;
    localparam int c_AW        = $clog2(c_RAM_DEPTH);
    localparam int c_SB_W      = EMPTY_W + 2;
    localparam int c_SW        = DATA_WIDTH + c_SB_W;
    localparam int c_BYTES     = DATA_WIDTH / 8;
    localparam logic [c_AW-1:0]    c_PTR_LAST = c_AW'(c_RAM_DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_ONE      = c_CNT_W'(1);
    localparam logic [11:0]        c_PKT_MAX  = 12'hFFF;

    logic [c_CNT_W-1:0]    r_count;
    logic [11:0]           r_pkt;
    logic [c_AW-1:0]       r_wr_ptr;
    logic [c_AW-1:0]       r_rd_ptr;
    logic [c_SB_W-1:0]     r_sb;
    logic [c_SW-1:0]       r_out;
    logic [15:0]           r_thr;
    logic                  r_irq_en;
    logic                  r_irq;
    logic [31:0]           r_rdata;
    logic [c_SW-1:0]       r_mem [0:c_RAM_DEPTH-1];

    logic                  w_full;
    logic                  w_empty;
    logic                  w_af;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_ram_wr;
    logic                  w_ram_rd;
    logic                  w_out_from_push;
    logic                  w_pk_inc;
    logic                  w_pk_dec;
    logic [DATA_WIDTH-1:0] w_swapped;
    logic [c_SW-1:0]       w_push_word;
    logic [c_SW-1:0]       w_ram_q;
    logic [15:0]           w_wr_thr;
    logic                  w_wr_irq_en;
    logic [31:0]           w_status;

    generate
        if (BYTE_SWAP != 0) begin : g_swap
            for (genvar k = 0; k < c_BYTES; k++) begin : g_byte
                assign w_swapped[8*k +: 8] =
                    avalonmm_write_slave_writedata[8*(c_BYTES-1-k) +: 8];
            end
        end else begin : g_noswap
            assign w_swapped = avalonmm_write_slave_writedata;
        end

        if (DATA_WIDTH >= 32) begin : g_ctrl_wide
            assign w_wr_thr    = avalonmm_write_slave_writedata[15:0];
            assign w_wr_irq_en = avalonmm_write_slave_writedata[31];
        end else if (DATA_WIDTH >= 16) begin : g_ctrl_mid
            assign w_wr_thr    = avalonmm_write_slave_writedata[15:0];
            assign w_wr_irq_en = 1'b0;
        end else begin : g_ctrl_narrow
            assign w_wr_thr    = {{(16-DATA_WIDTH){1'b0}}, avalonmm_write_slave_writedata};
            assign w_wr_irq_en = 1'b0;
        end
    endgenerate

    function automatic logic [c_AW-1:0] f_ptr_inc(input logic [c_AW-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign w_full   = (r_count == c_DEPTH);
    assign w_empty  = (r_count == '0);
    assign w_af     = (16'(r_count) >= r_thr);
    assign w_push   = avalonmm_write_slave_write && (avalonmm_write_slave_address == 2'd0)
                      && !w_full && !reset;
    assign w_pop    = !w_empty && avalonst_source_ready && !reset;

    // The output register holds the head word; the RAM only holds words behind it.
    assign w_out_from_push = w_push && (w_empty || (w_pop && r_count == c_ONE));
    assign w_ram_wr        = w_push && !w_out_from_push;
    assign w_ram_rd        = w_pop && (r_count > c_ONE);
    assign w_push_word     = {w_swapped, r_sb};
    assign w_ram_q         = r_mem[r_rd_ptr];

    assign w_pk_inc = w_push && r_sb[1];
    assign w_pk_dec = w_pop && r_out[1];
    assign w_status = {r_pkt, 1'b0, w_af, w_empty, w_full, 16'(r_count)};

    always_ff @(posedge wrclock) begin
        if (w_ram_wr) begin
            r_mem[r_wr_ptr] <= w_push_word;
        end
    end

    always_ff @(posedge wrclock) begin
        if (reset) begin
            r_count  <= '0;
            r_pkt    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_sb     <= '0;
            r_out    <= '0;
            r_thr    <= 16'(AFULL_DEFAULT);
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end

            if (w_pk_inc && !w_pk_dec && r_pkt != c_PKT_MAX) begin
                r_pkt <= r_pkt + 1'b1;
            end else if (w_pk_dec && !w_pk_inc && r_pkt != '0) begin
                r_pkt <= r_pkt - 1'b1;
            end

            if (w_ram_wr) begin
                r_wr_ptr <= f_ptr_inc(r_wr_ptr);
            end
            if (w_ram_rd) begin
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            end

            if (w_out_from_push) begin
                r_out <= w_push_word;
            end else if (w_ram_rd) begin
                r_out <= w_ram_q;
            end

            if (w_push) begin
                r_sb <= '0;
            end else if (avalonmm_write_slave_write && avalonmm_write_slave_address == 2'd1) begin
                r_sb <= avalonmm_write_slave_writedata[c_SB_W-1:0];
            end

            if (avalonmm_write_slave_write && avalonmm_write_slave_address == 2'd3) begin
                r_thr    <= w_wr_thr;
                r_irq_en <= w_wr_irq_en;
            end

            r_irq <= w_af && r_irq_en;

            if (avalonmm_write_slave_read) begin
                case (avalonmm_write_slave_address)
                    2'd2:    r_rdata <= w_status;
                    2'd3:    r_rdata <= {r_irq_en, 15'd0, r_thr};
                    default: r_rdata <= '0;
                endcase
            end
        end
    end

    assign avalonmm_write_slave_waitrequest = reset ||
        (avalonmm_write_slave_write && avalonmm_write_slave_address == 2'd0 && w_full);
    assign avalonmm_write_slave_readdata  = r_rdata;
    assign avalonst_source_valid          = !w_empty;
    assign avalonst_source_data           = r_out[c_SW-1:c_SB_W];
    assign avalonst_source_empty          = r_out[c_SB_W-1:2];
    assign avalonst_source_endofpacket    = r_out[1];
    assign avalonst_source_startofpacket  = r_out[0];
    assign irq                            = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_sub_top_mm_to_st_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module : tb_sub_top_mm_to_st_pkt_fifo
// Brief  : Directed and random bench with a queue-based reference model
// Rev    : 1.0  initial release
// ============================================================================
module tb_sub_top_mm_to_st_pkt_fifo;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int EW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    addr;
    logic          wr;
    logic          rd;
    logic [DW-1:0] wdata;
    logic [31:0]   rdata;
    logic          wreq;
    logic [DW-1:0] sdata;
    logic          svalid;
    logic          srdy;
    logic          ssop;
    logic          seop;
    logic [EW-1:0] semp;
    logic          irq;

    always #5 clk = ~clk;

    sub_top_mm_to_st_pkt_fifo #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .BYTE_SWAP(1), .AFULL_DEFAULT(14)
    ) dut (
        .wrclock                          (clk),
        .reset                            (rst),
        .avalonmm_write_slave_address     (addr),
        .avalonmm_write_slave_write       (wr),
        .avalonmm_write_slave_read        (rd),
        .avalonmm_write_slave_writedata   (wdata),
        .avalonmm_write_slave_readdata    (rdata),
        .avalonmm_write_slave_waitrequest (wreq),
        .avalonst_source_data             (sdata),
        .avalonst_source_valid            (svalid),
        .avalonst_source_ready            (srdy),
        .avalonst_source_startofpacket    (ssop),
        .avalonst_source_endofpacket      (seop),
        .avalonst_source_empty            (semp),
        .irq                              (irq)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        sop;
        logic        eop;
        logic [1:0]  emp;
    } ent_t;

    ent_t        q[$];
    logic [3:0]  m_sb;
    logic [15:0] m_thr;
    logic        m_en;
    logic        m_irq;
    logic [31:0] m_rd;
    int          checks   = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int pkt_count();
        int n = 0;
        foreach (q[i]) if (q[i].eop) n++;
        return (n > 4095) ? 4095 : n;
    endfunction

    function automatic logic [31:0] status_model();
        logic [31:0] st = '0;
        st[15:0]  = 16'(q.size());
        st[16]    = (q.size() == DEPTH);
        st[17]    = (q.size() == 0);
        st[18]    = (q.size() >= int'(m_thr));
        st[31:20] = 12'(pkt_count());
        return st;
    endfunction

    function automatic ent_t make_entry(input logic [31:0] w);
        ent_t e;
        for (int k = 0; k < 4; k++) e.d[8*k +: 8] = w[8*(3-k) +: 8];
        e.sop = m_sb[0];
        e.eop = m_sb[1];
        e.emp = m_sb[3:2];
        return e;
    endfunction

    task automatic check_outputs();
        chk("valid", svalid, q.size() > 0);
        if (q.size() > 0) begin
            chk("data", sdata, q[0].d);
            chk("sop", ssop, q[0].sop);
            chk("eop", seop, q[0].eop);
            chk("empty", semp, q[0].emp);
        end
        chk("irq", irq, m_irq);
        chk("readdata", rdata, m_rd);
    endtask

    // One clock: check waitrequest, advance the model, then check outputs.
    task automatic cycle();
        bit          push;
        bit          pop;
        logic [31:0] st;
        logic        irq_n;
        #1;
        chk("waitrequest", wreq, rst || (wr && addr == 2'd0 && q.size() == DEPTH));
        push  = !rst && wr && addr == 2'd0 && q.size() < DEPTH;
        pop   = !rst && q.size() > 0 && srdy;
        st    = status_model();
        irq_n = (q.size() >= int'(m_thr)) && m_en;
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            m_sb = '0; m_thr = 16'd14; m_en = 1'b0; m_irq = 1'b0; m_rd = '0;
        end else begin
            if (rd) m_rd = (addr == 2'd2) ? st : (addr == 2'd3) ? {m_en, 15'd0, m_thr} : 32'd0;
            m_irq = irq_n;
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(make_entry(wdata));
                m_sb = '0;
            end else if (wr && addr == 2'd1) begin
                m_sb = wdata[3:0];
            end
            if (wr && addr == 2'd3) begin
                m_thr = wdata[15:0];
                m_en  = wdata[31];
            end
        end
        check_outputs();
    endtask

    task automatic idle(input int n);
        wr = 1'b0; rd = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic mm_write(input logic [1:0] a, input logic [31:0] d);
        bit stalled;
        wr = 1'b1; rd = 1'b0; addr = a; wdata = d;
        for (int g = 0; g < 40; g++) begin
            stalled = (a == 2'd0 && q.size() == DEPTH);
            cycle();
            if (!stalled) break;
            if (g == 39) chk("write_timeout", wreq, 1'b0);
        end
        wr = 1'b0;
    endtask

    task automatic mm_read(input logic [1:0] a);
        wr = 1'b0; rd = 1'b1; addr = a;
        cycle();
        rd = 1'b0;
    endtask

    task automatic drain();
        wr = 1'b0; rd = 1'b0; srdy = 1'b1;
        for (int i = 0; i < DEPTH + 4 && q.size() > 0; i++) cycle();
        chk("drain_valid", svalid, 1'b0);
        srdy = 1'b0;
    endtask

    initial begin
        rst = 1'b1; addr = '0; wr = 1'b0; rd = 1'b0; wdata = '0; srdy = 1'b0;
        m_sb = '0; m_thr = 16'd14; m_en = 1'b0; m_irq = 1'b0; m_rd = '0;
        repeat (3) cycle();
        rst = 1'b0;
        chk("rst_valid", svalid, 1'b0);
        chk("rst_irq", irq, 1'b0);
        chk("rst_readdata", rdata, 32'd0);
        mm_read(2'd3);
        chk("rst_thr", rdata, 32'h0000_000E);

        // Single push with sop/eop, then sideband must be cleared
        srdy = 1'b1;
        mm_write(2'd1, 32'h3);
        mm_write(2'd0, 32'h1122_3344);
        chk("sp_valid", svalid, 1'b1);
        chk("sp_data", sdata, 32'h4433_2211);
        chk("sp_sopeop", {seop, ssop}, 2'b11);
        idle(1);
        chk("sp_gone", svalid, 1'b0);
        srdy = 1'b0;
        mm_write(2'd0, 32'hA5A5_0001);
        chk("sb_cleared", {seop, ssop}, 2'b00);
        drain();

        // Fill to DEPTH, stall the 17th write until one pop
        for (int i = 0; i < DEPTH; i++) mm_write(2'd0, $urandom);
        mm_read(2'd2);
        chk("fill_status", rdata, 32'h0005_0010);
        wr = 1'b1; addr = 2'd0; wdata = $urandom;
        cycle();
        chk("stall0", wreq, 1'b1);
        cycle();
        chk("stall1", wreq, 1'b1);
        srdy = 1'b1;
        cycle();
        chk("stall_release", wreq, 1'b0);
        srdy = 1'b0;
        cycle();
        wr = 1'b0;
        mm_read(2'd2);
        chk("refill_status", rdata, 32'h0005_0010);
        drain();

        // Simultaneous push and pop at level 5
        for (int i = 0; i < 5; i++) mm_write(2'd0, $urandom);
        srdy = 1'b1; wr = 1'b1; addr = 2'd0;
        for (int i = 0; i < 10; i++) begin
            wdata = $urandom;
            cycle();
        end
        wr = 1'b0; srdy = 1'b0;
        mm_read(2'd2);
        chk("pp_level", rdata[15:0], 16'd5);
        drain();

        // Packet count: two 3-word packets, then pop one packet
        for (int p = 0; p < 2; p++) begin
            mm_write(2'd1, 32'h1);
            mm_write(2'd0, $urandom);
            mm_write(2'd0, $urandom);
            mm_write(2'd1, 32'h2);
            mm_write(2'd0, $urandom);
        end
        mm_read(2'd2);
        chk("pkt_two", rdata[31:20], 12'd2);
        srdy = 1'b1;
        idle(3);
        srdy = 1'b0;
        mm_read(2'd2);
        chk("pkt_one", rdata[31:20], 12'd1);
        drain();

        // irq at threshold 4
        mm_write(2'd3, 32'h8000_0004);
        for (int i = 0; i < 4; i++) mm_write(2'd0, $urandom);
        chk("irq_pre", irq, 1'b0);
        idle(1);
        chk("irq_set", irq, 1'b1);
        srdy = 1'b1;
        idle(1);
        srdy = 1'b0;
        chk("irq_hold", irq, 1'b1);
        idle(1);
        chk("irq_clr", irq, 1'b0);
        drain();
        mm_write(2'd3, 32'h0000_000E);

        // Reset at level 7 discards everything
        for (int i = 0; i < 7; i++) mm_write(2'd0, $urandom);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst2_valid", svalid, 1'b0);
        mm_read(2'd2);
        chk("rst2_status", rdata, 32'h0002_0000);
        mm_read(2'd3);
        chk("rst2_thr", rdata, 32'h0000_000E);
        srdy = 1'b1;
        idle(4);
        chk("rst2_nostale", svalid, 1'b0);

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            int unsigned r;
            r    = $urandom_range(0, 99);
            srdy = 1'($urandom_range(0, 1));
            rst  = (r == 0);
            wr   = 1'b0; rd = 1'b0;
            addr = 2'($urandom);
            wdata = $urandom;
            if (r >= 1 && r < 48) begin
                wr = 1'b1; addr = 2'd0;
            end else if (r < 62) begin
                wr = 1'b1; addr = 2'd1; wdata = 32'($urandom_range(0, 15));
            end else if (r < 67) begin
                wr = 1'b1; addr = 2'd3;
                wdata = 32'($urandom_range(0, 17));
                wdata[31] = 1'($urandom_range(0, 1));
            end else if (r < 70) begin
                wr = 1'b1; addr = 2'd2;
            end else if (r < 85) begin
                rd = 1'b1;
            end
            cycle();
        end
        rst = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
